// File: rtl/cpu_pkg.sv
// Shared CPU package: fetch constants, instruction-memory window,
// fetch state encoding and the address-error check helper.
package cpu_pkg;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] IM_BASE   = 32'h0000_3000;
  localparam logic [31:0] IM_LAST   = 32'h0000_6FFC;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  function automatic logic pc_bad(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);
  endfunction

endpackage

// File: rtl/fd_reg.sv
// F/D pipeline register: hold when disabled, load an instruction
// or a bubble when enabled, asynchronous active-high reset.
module fd_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic        adel_in,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        valid,
  output logic        exc_adel
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr    <= NOP_INSTR;
      pc       <= PC_RESET;
      valid    <= 1'b0;
      exc_adel <= 1'b0;
    end else if (en) begin
      if (load) begin
        instr    <= instr_in;
        pc       <= pc_in;
        valid    <= 1'b1;
        exc_adel <= adel_in;
      end else begin
        // bubble keeps pc so D still sees a sane address
        instr    <= NOP_INSTR;
        valid    <= 1'b0;
        exc_adel <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, FETCH/HOLD sequencing, delayed-branch redirect.
// Define FETCH_ADEL_EN to enable the fetch address-error check.
module fetch_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en_PC,
  input  logic        en_F,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc8_D,
  output logic        valid_D,
  output logic        exc_adel_D,
  output logic        fetch_busy
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         pend;
  logic [31:0]  pend_pc;
  logic [31:0]  hold_buf;

  logic         adel;
  logic         ack_ok;
  logic         ready;
  logic         deliver;
  logic         take;
  logic [31:0]  instr_f;
  logic [31:0]  next_pc;

`ifdef FETCH_ADEL_EN
  assign adel = (state == FETCH) && pc_bad(pc);
`else
  assign adel = 1'b0;
`endif

  assign imem_req   = !reset && (state == FETCH) && !adel;
  assign imem_addr  = pc;
  assign ack_ok     = imem_req && imem_ack;
  assign ready      = (state == HOLD) || ack_ok || adel;
  assign deliver    = ready && en_F && en_PC;
  assign take       = redirect_valid && valid_D && en_F;
  assign fetch_busy = !ready;

  always_comb begin
    instr_f = imem_rdata;
    unique case (1'b1)
      (state == HOLD): instr_f = hold_buf;
      adel:            instr_f = NOP_INSTR;
      default: ;
    endcase
  end

  always_comb begin
    next_pc = pc + 32'd4;
    unique case (1'b1)
      take:          next_pc = redirect_pc;
      (!take&&pend): next_pc = pend_pc;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= PC_RESET;
      pend     <= 1'b0;
      pend_pc  <= 32'h0;
      hold_buf <= 32'h0;
    end else if (deliver) begin
      state <= FETCH;
      pc    <= next_pc;
      pend  <= 1'b0;
    end else begin
      if (ack_ok) begin
        hold_buf <= imem_rdata;
        state    <= HOLD;
      end
      // branch left D before its target could be used
      if (take) begin
        pend    <= 1'b1;
        pend_pc <= redirect_pc;
      end
    end
  end

  fd_reg u_fd (
    .clk      (clk),
    .reset    (reset),
    .en       (en_F),
    .load     (deliver),
    .instr_in (instr_f),
    .pc_in    (pc),
    .adel_in  (adel),
    .instr    (instr_D),
    .pc       (pc_D),
    .valid    (valid_D),
    .exc_adel (exc_adel_D)
  );

  assign pc8_D = pc_D + 32'd8;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then
// randomized stalls/acks/redirects against a stream-level model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_PC, en_F, redirect_valid, imem_ack;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, valid_D, exc_adel_D, fetch_busy;
  logic [31:0] imem_addr, instr_D, pc_D, pc8_D;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_hb, m_tgt, m_instr, m_pcd;
  logic        m_buf, m_pend, m_valid, m_exc;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .en_PC          (en_PC),
    .en_F           (en_F),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_D        (instr_D),
    .pc_D           (pc_D),
    .pc8_D          (pc8_D),
    .valid_D        (valid_D),
    .exc_adel_D     (exc_adel_D),
    .fetch_busy     (fetch_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] + a[15:0] + 16'h1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h3000; m_hb = 32'h0; m_tgt = 32'h0;
    m_buf = 1'b0; m_pend = 1'b0;
    m_instr = 32'h0; m_pcd = 32'h3000; m_valid = 1'b0; m_exc = 1'b0;
  endtask

  task automatic chk_d();
    chk("pc_D", pc_D, m_pcd);
    chk("instr_D", instr_D, m_instr);
    chk1("valid_D", valid_D, m_valid);
    chk1("exc_adel_D", exc_adel_D, m_exc);
    chk("pc8_D", pc8_D, m_pcd + 32'd8);
  endtask

  // one clock: drive at negedge, check comb outputs, advance model, check D
  task automatic cyc(input logic epc, input logic ef, input logic rv,
                     input logic [31:0] rpc, input logic ack);
    logic adel, req, ackv, ready, deliver, take;
    logic [31:0] inst;
    en_PC = epc; en_F = ef; redirect_valid = rv; redirect_pc = rpc;
    imem_ack = ack; imem_rdata = mem_word(m_pc);
`ifdef FETCH_ADEL_EN
    adel = !m_buf && (m_pc[1:0] != 2'b00 || m_pc < 32'h3000 ||
                      m_pc > 32'h6FFC);
`else
    adel = 1'b0;
`endif
    req     = !m_buf && !adel;
    ackv    = req && ack;
    ready   = m_buf || ackv || adel;
    inst    = m_buf ? m_hb : (adel ? 32'h0 : imem_rdata);
    take    = rv && m_valid && ef;
    deliver = ready && ef && epc;
    #1;
    chk1("imem_req", imem_req, req);
    if (req) chk("imem_addr", imem_addr, m_pc);
    chk1("fetch_busy", fetch_busy, !ready);
    if (deliver) begin
      m_instr = inst; m_pcd = m_pc; m_valid = 1'b1; m_exc = adel;
      m_pc = take ? rpc : (m_pend ? m_tgt : m_pc + 32'd4);
      m_pend = 1'b0; m_buf = 1'b0;
    end else begin
      if (ef) begin m_instr = 32'h0; m_valid = 1'b0; m_exc = 1'b0; end
      if (ackv) begin m_buf = 1'b1; m_hb = imem_rdata; end
      if (take) begin m_pend = 1'b1; m_tgt = rpc; end
    end
    @(posedge clk); #1;
    chk_d();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b1; en_PC = 1'b0; en_F = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_pc_D", pc_D, 32'h3000);
    chk("rst_instr_D", instr_D, 32'h0);
    chk1("rst_valid_D", valid_D, 1'b0);
    chk1("rst_exc", exc_adel_D, 1'b0);
    chk1("rst_req", imem_req, 1'b0);
    reset = 1'b0;

    // sequential fetch, zero-wait
    cyc(1, 1, 0, 32'h0, 1); chk("seq0", pc_D, 32'h3000);
    cyc(1, 1, 0, 32'h0, 1); chk("seq1", pc_D, 32'h3004);
    // stall two cycles with ack at 0x3008
    cyc(0, 0, 0, 32'h0, 1);
    cyc(0, 0, 0, 32'h0, 0);
    chk("frozen_pc", pc_D, 32'h3004);
    cyc(1, 1, 0, 32'h0, 0);
    chk("held_pc", pc_D, 32'h3008);
    chk("held_instr", instr_D, mem_word(32'h3008));
    chk("next_addr", imem_addr, 32'h300C);
    // branch at 0x3010 in D
    cyc(1, 1, 0, 32'h0, 1);
    cyc(1, 1, 0, 32'h0, 1); chk("br_pc", pc_D, 32'h3010);
    cyc(1, 1, 1, 32'h3100, 1); chk("slot", pc_D, 32'h3014);
    cyc(1, 1, 0, 32'h0, 1); chk("target", pc_D, 32'h3100);
    // delay-slot fetch waits three cycles while redirect pending
    cyc(1, 1, 0, 32'h0, 1);
    cyc(1, 1, 1, 32'h3200, 0); chk1("bub_valid", valid_D, 1'b0);
    cyc(1, 1, 1, 32'h3300, 0);
    cyc(1, 1, 1, 32'h3300, 0); chk1("bub_busy", fetch_busy, 1'b1);
    cyc(1, 1, 0, 32'h0, 1); chk("late_slot", pc_D, 32'h3108);
    cyc(1, 1, 0, 32'h0, 1); chk("pend_tgt", pc_D, 32'h3200);
    // jr to a misaligned target
    cyc(1, 1, 1, 32'h3002, 1);
    cyc(1, 1, 0, 32'h0, 1);
    chk("jr_pc", pc_D, 32'h3002);
`ifdef FETCH_ADEL_EN
    chk1("jr_exc", exc_adel_D, 1'b1);
    chk("jr_instr", instr_D, 32'h0);
`else
    chk1("jr_exc", exc_adel_D, 1'b0);
`endif
    cyc(1, 1, 1, 32'h3400, 1);
    cyc(1, 1, 0, 32'h0, 1);
    cyc(1, 1, 0, 32'h0, 1); chk("pre_rst", pc_D, 32'h3404);
    // reset asserted mid-wait
    imem_ack = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_pc_D", pc_D, 32'h3000);
    chk1("arst_valid", valid_D, 1'b0);
    chk("arst_instr", instr_D, 32'h0);
    chk1("arst_req", imem_req, 1'b0);
    model_reset();
    @(negedge clk);
    imem_ack = 1'b1;
    reset = 1'b0;
    #1;
    chk1("post_rst_req", imem_req, 1'b1);
    chk("post_rst_addr", imem_addr, 32'h3000);
    cyc(1, 1, 0, 32'h0, 1);
    chk("post_rst_pc", pc_D, 32'h3000);

    // randomized stalls, acks and redirects
    for (int i = 0; i < 400; i++) begin
      r = 32'h3000 + 32'($urandom_range(0, 4095)) * 32'd4;
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
          $urandom_range(0, 4) == 0, r, $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
